// File: rtl/out_port_arbiter_if.sv
// Output-port link bundle: requester flits/valids/readies plus the single output link.
// The arbiter takes the slave side; requesters and the downstream link sit on the master side.
interface out_port_arbiter_if #(
  parameter int unsigned FLIT_SIZE = 13,
  parameter int unsigned REQ_NUM   = 5
);
  logic [REQ_NUM-1:0]           in_w;
  logic [REQ_NUM*FLIT_SIZE-1:0] data_i;
  logic [REQ_NUM-1:0]           out_r;
  logic                         out_w;
  logic [FLIT_SIZE-1:0]         data_o;
  logic                         in_r;

  modport slave  (input in_w, data_i, in_r, output out_r, out_w, data_o);
  modport master (output in_w, data_i, in_r, input out_r, out_w, data_o);
endinterface

// File: rtl/out_port_arbiter.sv
// Wormhole round-robin arbiter for one switch output port: grant held head..tail, then rotates.
// Optional stall watchdog enabled by defining PGNOC_ARB_TIMEOUT_EN.
module out_port_arbiter #(
  parameter int unsigned FLIT_SIZE = 13,
  parameter int unsigned REQ_NUM   = 5,
  parameter int unsigned CNT_SIZE  = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       a_rst,
  out_port_arbiter_if.slave          bus,
  output logic                       busy,
  output logic [$clog2(REQ_NUM)-1:0] grant_idx,
  output logic [CNT_SIZE-1:0]        pkt_cnt,
  output logic                       timeout
);
  localparam int unsigned IW = $clog2(REQ_NUM);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        ptr, ptr_n, grant_n, next_g;
  logic [IW:0]          pick;
  logic                 own_w;
  logic [FLIT_SIZE-1:0] own_flit;
  logic                 cnt_inc;

  // First requester at or after p, wrapping; MSB flags that one was found.
  function automatic logic [IW:0] rr_pick(input logic [IW-1:0] p, input logic [REQ_NUM-1:0] req);
    logic [IW:0] r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      k = 32'(p) + i;
      if (k >= REQ_NUM) k = k - REQ_NUM;
      if (!r[IW] && req[IW'(k)]) r = {1'b1, IW'(k)};
    end
    return r;
  endfunction

  assign busy   = (state == BUSY);
  assign pick   = rr_pick(ptr, bus.in_w);
  assign next_g = (grant_idx == IW'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    own_w     = 1'b0;
    own_flit  = '0;
    bus.out_r = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (IW'(i) == grant_idx) begin
        own_w        = bus.in_w[i];
        own_flit     = bus.data_i[i*FLIT_SIZE +: FLIT_SIZE];
        bus.out_r[i] = busy & bus.in_r;
      end
    end
    bus.out_w  = busy & own_w;
    bus.data_o = (busy && own_w) ? own_flit : '0;
  end

`ifdef PGNOC_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
  logic          force_rel;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_idx;
    cnt_inc = 1'b0;
`ifdef PGNOC_ARB_TIMEOUT_EN
    force_rel = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (pick[IW]) begin
          state_n = BUSY;
          grant_n = pick[IW-1:0];
        end
      end
      BUSY: begin
        if (own_w && bus.in_r && own_flit[FLIT_SIZE-1]) begin
          state_n = IDLE;
          ptr_n   = next_g;
          cnt_inc = 1'b1;
        end
`ifdef PGNOC_ARB_TIMEOUT_EN
        // This stall cycle brings the counter to TIMEOUT: release without counting a packet.
        else if (!own_w && stall_cnt == SW'(TIMEOUT - 1)) begin
          state_n   = IDLE;
          ptr_n     = next_g;
          force_rel = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= grant_n;
      if (cnt_inc) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

`ifdef PGNOC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= force_rel;
      if (!busy || own_w) stall_cnt <= '0;
      else                stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // TIMEOUT only feeds the stall watchdog; referenced so the base build still consumes it.
  assign timeout = 1'b0 & (TIMEOUT != 0);
`endif
endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed vector bench for out_port_arbiter: reset, wormhole hold, round-robin, backpressure,
// non-owner blocking and owner stall (watchdog release when PGNOC_ARB_TIMEOUT_EN is defined).
module tb_out_port_arbiter;
  localparam int unsigned FS = 13;
  localparam int unsigned RN = 5;
  localparam int unsigned CS = 16;
  localparam int unsigned IW = 3;
`ifdef PGNOC_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic          clk = 1'b0;
  logic          a_rst;
  logic          busy;
  logic [IW-1:0] grant_idx;
  logic [CS-1:0] pkt_cnt;
  logic          timeout;

  always #5 clk = ~clk;

  out_port_arbiter_if #(.FLIT_SIZE(FS), .REQ_NUM(RN)) bus ();

  out_port_arbiter #(.FLIT_SIZE(FS), .REQ_NUM(RN), .CNT_SIZE(CS), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx),
    .pkt_cnt   (pkt_cnt),
    .timeout   (timeout)
  );

  typedef struct {
    logic             rst_n;
    logic [RN-1:0]    w;
    logic [RN*FS-1:0] d;
    logic             rdy;
    logic             e_busy;
    logic [IW-1:0]    e_g;
    logic             e_ow;
    logic [FS-1:0]    e_d;
    logic [RN-1:0]    e_or;
    logic [CS-1:0]    e_pkt;
    logic             e_to;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkv(input logic rst_n, input logic [RN-1:0] w, input logic [RN*FS-1:0] d,
                               input logic rdy, input logic eb, input logic [IW-1:0] eg, input logic eow,
                               input logic [FS-1:0] ed, input logic [RN-1:0] eor, input logic [CS-1:0] epkt,
                               input logic eto);
    vec_t v;
    v.rst_n = rst_n; v.w = w; v.d = d; v.rdy = rdy;
    v.e_busy = eb; v.e_g = eg; v.e_ow = eow; v.e_d = ed; v.e_or = eor; v.e_pkt = epkt; v.e_to = eto;
    return v;
  endfunction

  function automatic logic [RN*FS-1:0] put(input logic [RN*FS-1:0] base, input int unsigned k,
                                           input logic [FS-1:0] f);
    base[k*FS +: FS] = f;
    return base;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the edge, check outputs, then advance one clock.
  task automatic apply_vec(input vec_t v, input string tag);
    a_rst      = v.rst_n;
    bus.in_w   = v.w;
    bus.data_i = v.d;
    bus.in_r   = v.rdy;
    #1;
    chk({tag, ".busy"},    32'(busy),       32'(v.e_busy));
    chk({tag, ".grant"},   32'(grant_idx),  32'(v.e_g));
    chk({tag, ".out_w"},   32'(bus.out_w),  32'(v.e_ow));
    chk({tag, ".data_o"},  32'(bus.data_o), 32'(v.e_d));
    chk({tag, ".out_r"},   32'(bus.out_r),  32'(v.e_or));
    chk({tag, ".pkt_cnt"}, 32'(pkt_cnt),    32'(v.e_pkt));
    chk({tag, ".timeout"}, 32'(timeout),    32'(v.e_to));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    logic [RN*FS-1:0] rd;
    rd = (RN*FS)'({$urandom(), $urandom(), $urandom()});
    apply_vec(mkv(1'b0, RN'($urandom()), rd, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0), tag);
    apply_vec(mkv(1'b0, RN'($urandom()), rd, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0), tag);
  endtask

  initial begin
    logic [RN*FS-1:0] d, dall;
    logic [FS-1:0]    f;
    int unsigned      g;

    a_rst = 1'b0; bus.in_w = '0; bus.data_i = '0; bus.in_r = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then a three-flit packet from requester 2.
    d = (RN*FS)'({$urandom(), $urandom(), $urandom()});
    tbl.push_back(mkv(1'b0, 5'b10110, d, 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b0));
    tbl.push_back(mkv(1'b0, 5'b01011, d, 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b0));
    tbl.push_back(mkv(1'b1, 5'b00100, put('0, 2, 13'h0111), 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 16'd0, 1'b0));
    tbl.push_back(mkv(1'b1, 5'b00100, put('0, 2, 13'h0111), 1'b1, 1'b1, 3'd2, 1'b1, 13'h0111, 5'b00100, 16'd0, 1'b0));
    tbl.push_back(mkv(1'b1, 5'b00100, put('0, 2, 13'h0222), 1'b1, 1'b1, 3'd2, 1'b1, 13'h0222, 5'b00100, 16'd0, 1'b0));
    tbl.push_back(mkv(1'b1, 5'b00100, put('0, 2, 13'h1333), 1'b1, 1'b1, 3'd2, 1'b1, 13'h1333, 5'b00100, 16'd0, 1'b0));
    tbl.push_back(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b0, 3'd2, 1'b0, '0, '0, 16'd1, 1'b0));
    // Fresh reset, then all requesters with single-flit packets: 0,1,2,3,4,0 with a bubble between.
    dall = '0;
    for (int unsigned k = 0; k < RN; k++) dall = put(dall, k, FS'(32'h1000 | (32'hA0 + k)));
    tbl.push_back(mkv(1'b0, 5'b11111, dall, 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b0));
    for (int unsigned i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        g = (i == 0) ? 0 : (i / 2 - 1) % RN;
        tbl.push_back(mkv(1'b1, 5'b11111, dall, 1'b1, 1'b0, IW'(g), 1'b0, '0, '0, CS'(i / 2), 1'b0));
      end else begin
        g = (i / 2) % RN;
        f = FS'(32'h1000 | (32'hA0 + g));
        tbl.push_back(mkv(1'b1, 5'b11111, dall, 1'b1, 1'b1, IW'(g), 1'b1, f, RN'(1 << g), CS'(i / 2), 1'b0));
      end
    end
    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure mid-packet on requester 4.
    do_reset("bp_rst");
    apply_vec(mkv(1'b1, 5'b10000, put('0, 4, 13'h0044), 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 16'd0, 1'b0), "bp_idle");
    apply_vec(mkv(1'b1, 5'b10000, put('0, 4, 13'h0044), 1'b1, 1'b1, 3'd4, 1'b1, 13'h0044, 5'b10000, 16'd0, 1'b0), "bp_head");
    for (int i = 0; i < 4; i++)
      apply_vec(mkv(1'b1, 5'b10000, put('0, 4, 13'h0055), 1'b0, 1'b1, 3'd4, 1'b1, 13'h0055, 5'b00000, 16'd0, 1'b0),
                $sformatf("bp_stall%0d", i));
    apply_vec(mkv(1'b1, 5'b10000, put('0, 4, 13'h0055), 1'b1, 1'b1, 3'd4, 1'b1, 13'h0055, 5'b10000, 16'd0, 1'b0), "bp_body");
    apply_vec(mkv(1'b1, 5'b10000, put('0, 4, 13'h1066), 1'b1, 1'b1, 3'd4, 1'b1, 13'h1066, 5'b10000, 16'd0, 1'b0), "bp_tail");
    apply_vec(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b0, 3'd4, 1'b0, '0, '0, 16'd1, 1'b0), "bp_done");

    // Requester 3 waits behind requester 1's four-flit packet.
    do_reset("blk_rst");
    apply_vec(mkv(1'b1, 5'b00010, put('0, 1, 13'h0011), 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 16'd0, 1'b0), "blk_idle");
    for (int unsigned i = 0; i < 4; i++) begin
      f = FS'((i == 3 ? 32'h1000 : 32'h0) | (32'h11 * (i + 1)));
      d = put(put('0, 1, f), 3, 13'h1077);
      apply_vec(mkv(1'b1, 5'b01010, d, 1'b1, 1'b1, 3'd1, 1'b1, f, 5'b00010, 16'd0, 1'b0), $sformatf("blk_f%0d", i));
    end
    apply_vec(mkv(1'b1, 5'b01000, put('0, 3, 13'h1077), 1'b1, 1'b0, 3'd1, 1'b0, '0, '0, 16'd1, 1'b0), "blk_bubble");
    apply_vec(mkv(1'b1, 5'b01000, put('0, 3, 13'h1077), 1'b1, 1'b1, 3'd3, 1'b1, 13'h1077, 5'b01000, 16'd1, 1'b0), "blk_g3");
    apply_vec(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b0, 3'd3, 1'b0, '0, '0, 16'd2, 1'b0), "blk_done");

    // Owner drops valid after its head flit.
    do_reset("drop_rst");
    apply_vec(mkv(1'b1, 5'b00001, put('0, 0, 13'h00AB), 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 16'd0, 1'b0), "drop_idle");
    apply_vec(mkv(1'b1, 5'b00001, put('0, 0, 13'h00AB), 1'b1, 1'b1, 3'd0, 1'b1, 13'h00AB, 5'b00001, 16'd0, 1'b0), "drop_head");
`ifdef PGNOC_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      apply_vec(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b1, 3'd0, 1'b0, '0, 5'b00001, 16'd0, 1'b0), $sformatf("drop_stall%0d", i));
    apply_vec(mkv(1'b1, 5'b11111, dall, 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 16'd0, 1'b1), "to_pulse");
    apply_vec(mkv(1'b1, 5'b11111, dall, 1'b1, 1'b1, 3'd1, 1'b1, 13'h10A1, 5'b00010, 16'd0, 1'b0), "to_next_g1");
    apply_vec(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b0, 3'd1, 1'b0, '0, '0, 16'd1, 1'b0), "to_done");
`else
    for (int i = 0; i < 12; i++)
      apply_vec(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b1, 3'd0, 1'b0, '0, 5'b00001, 16'd0, 1'b0), $sformatf("drop_stall%0d", i));
    apply_vec(mkv(1'b1, 5'b00001, put('0, 0, 13'h1ABC), 1'b1, 1'b1, 3'd0, 1'b1, 13'h1ABC, 5'b00001, 16'd0, 1'b0), "drop_tail");
    apply_vec(mkv(1'b1, 5'b00000, '0, 1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 16'd1, 1'b0), "drop_done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
